uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the UART TX path. It adds configurable data width, parity, stop bits and baud rate, plus an internal TX FIFO. Input uses a ready/valid handshake, so upstream logic (video/control packetiser) can burst bytes without polling a done pulse. It sits between the packetiser and the board TX pin, clocked by the 100 MHz system clock.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 4_000_000, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD clock cycles (integer division); DIV < 2 is an elaboration error
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal values 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of two >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
tx_data  input  DATA_BITS  word to send
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept a word (= not full)
tx_out  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line
tx_done_signal  output  1  one-cycle pulse on the last cycle of each frame's final stop bit
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): tx_out=1, tx_busy=0, tx_done_signal=0, fifo_level=0, FIFO flushed, FSM=IDLE, baud counter=0. tx_ready=1 once rst is released. Reset mid-frame aborts the frame; tx_out goes high immediately.
- Push: a word is written when tx_valid && tx_ready at a rising edge. tx_ready = (fifo_level != FIFO_DEPTH); it is combinational from registered state only, with no dependency on tx_valid.
- Full: no write occurs, even when a pop happens in the same cycle. A push and a pop in the same cycle on a non-full FIFO leave fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH. The extra level bit distinguishes full from empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the FIFO is not empty, pop the head into the shift register and go to START. tx_out falls on the same edge (registered).
- Latency: a word accepted into an empty FIFO at edge N drives tx_out low at edge N+1.
- Every state lasts DIV cycles, counted by a baud counter running 0..DIV-1. The counter resets to 0 on every state entry.
- START: tx_out=0, then go to DATA with bit index 0.
- DATA: tx_out = shift[0], LSB first. Shift right at each bit boundary. After DATA_BITS bits, go to PARITY if PARITY != 0, else go to STOP.
- PARITY: odd mode sends the bit that makes the total count of 1s in data+parity odd; even mode makes it even. Parity is computed over the popped word at pop time.
- STOP: tx_out=1 for STOP_BITS*DIV cycles. tx_done_signal pulses on the final cycle. On the next edge, if the FIFO is not empty, pop and enter START directly (no extra idle cycle); otherwise go to IDLE.
- tx_busy = (state != IDLE).
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles exactly. No drift between back-to-back frames.
- tx_data is sampled only at push; later changes to tx_data do not affect queued words.

Test Plan:
1. Defaults (DIV=25), push 0xA5 once -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 25 cycles, 250 cycles total; one tx_done_signal pulse at cycle 250; tx_busy then drops.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x35 -> bits 0,1,0,1,0,1,1,0, parity 0, stop 1,1; 275 cycles total. Rerun with PARITY=1, DATA_BITS=8, push 0x00 -> parity bit 1.
3. Hold tx_valid high for 20 words during the first frame -> exactly 16 words accepted, tx_ready low at fifo_level=16; tx_ready reasserts one cycle after the next pop; no word lost or duplicated.
4. Back-to-back: push 3 words -> 3 contiguous frames of 250 cycles with no idle gap; 3 done pulses spaced exactly 250 cycles apart; tx_busy high continuously.
5. Assert rst low at cycle 100 of a frame with 4 words queued -> tx_out=1 and fifo_level=0 immediately; after release no residual frame is sent and tx_ready=1.
6. Push and pop in the same cycle at fifo_level=5 -> level stays 5; push while full during a pop -> write rejected, level drops to FIFO_DEPTH-1.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an internal TX FIFO and a ready/valid input.
// Frame: start, DATA_BITS (LSB first), optional parity, STOP_BITS stop bits; each bit lasts DIV clocks.
//   state    | meaning
//   S_IDLE   | line high, waiting for a word in the FIFO
//   S_START  | start bit (low)
//   S_DATA   | payload bits, LSB first
//   S_PARITY | parity bit (only when PARITY != 0)
//   S_STOP   | stop bit(s), high for STOP_BITS*DIV cycles
module uart_tx_fifo_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 4_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_done_signal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int STOP_LEN = STOP_BITS * DIV;
  localparam int CW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int IW       = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx_out;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_baud_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_nxt;
  logic                 w_tx_nxt;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  assign tx_ready       = (r_level != LVL_FULL);
  assign fifo_level     = r_level;
  assign tx_out         = r_tx_out;
  assign tx_busy        = (r_state != S_IDLE);
  assign w_empty        = (r_level == '0);
  assign w_push         = tx_valid && tx_ready;
  assign w_head         = r_mem[r_rptr];
  assign w_head_par     = (PARITY == 1) ? ~(^w_head) : (^w_head);
  assign w_bit_end      = (r_baud == BIT_LAST);
  assign w_stop_end     = (r_baud == STOP_LAST);
  assign tx_done_signal = (r_state == S_STOP) && w_stop_end;

  // Storage is not reset: entries are only read once r_level says they were written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx_out <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_par_nxt;
      r_tx_out <= w_tx_nxt;
    end
  end

  // tx_out is registered, so each branch drives the level for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_parity;
    w_tx_nxt    = r_tx_out;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_pop      = !w_empty;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_idx == IDX_LAST) begin
            if (PARITY != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + IW'(1);
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_stop_end) begin
          w_baud_nxt = '0;
          w_pop      = !w_empty;
          if (w_empty) begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Popping always starts a new frame, whether from IDLE or straight out of STOP.
    if (w_pop) begin
      w_state_nxt = S_START;
      w_baud_nxt  = '0;
      w_shift_nxt = w_head;
      w_par_nxt   = w_head_par;
      w_tx_nxt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: three instances (8N1, 7E2, 8O1) at DIV=25.
// Expected line frames are queued at push time; per-instance monitors decode the line and compare.
module tb_uart_tx_fifo_param;

  localparam int DIV = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [2:0] vld = '0;
  wire  [2:0] w_rdy, w_tx, w_busy, w_done;
  wire  [4:0] lvl0, lvl1, lvl2;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  uart_tx_fifo_param u_dut0 (
    .clk(clk), .rst(rst_n), .tx_data(d0), .tx_valid(vld[0]), .tx_ready(w_rdy[0]),
    .tx_out(w_tx[0]), .tx_busy(w_busy[0]), .tx_done_signal(w_done[0]), .fifo_level(lvl0));

  uart_tx_fifo_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst_n), .tx_data(d1), .tx_valid(vld[1]), .tx_ready(w_rdy[1]),
    .tx_out(w_tx[1]), .tx_busy(w_busy[1]), .tx_done_signal(w_done[1]), .fifo_level(lvl1));

  uart_tx_fifo_param #(.PARITY(1)) u_dut2 (
    .clk(clk), .rst(rst_n), .tx_data(d2), .tx_valid(vld[2]), .tx_ready(w_rdy[2]),
    .tx_out(w_tx[2]), .tx_busy(w_busy[2]), .tx_done_signal(w_done[2]), .fifo_level(lvl2));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int ch, input logic [15:0] f);
    case (ch)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  function automatic logic [15:0] qpop(input int ch);
    case (ch)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Decodes one frame per falling edge, sampling each bit mid-period, then expects the done pulse.
  task automatic monitor(input int ch);
    int          len, c0, cd;
    logic [15:0] got, exp;
    logic        abort, seen;
    len = (ch == 0) ? 10 : 11;
    forever begin
      @(negedge clk);
      if (rst_n && w_tx[ch] === 1'b0) begin
        c0 = cyc; got = '0; abort = 1'b0; seen = 1'b0; cd = 0;
        for (int i = 0; i < len; i++) begin
          repeat ((i == 0) ? 12 : DIV) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
          got[i] = w_tx[ch];
        end
        for (int k = 0; k < 30 && !seen; k++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
          if (w_done[ch] === 1'b1) begin
            seen = 1'b1;
            cd   = cyc;
          end
        end
        if (!abort) begin
          if (qsize(ch) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame ch%0d: got=0x%0h expected=none", ch, got);
          end else begin
            exp = qpop(ch);
            check($sformatf("frame_bits_ch%0d", ch), got, exp);
            check($sformatf("done_offset_ch%0d", ch), cd - c0, len * DIV - 1);
          end
        end
      end
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic [15:0] f);
    int t;
    t = 0;
    @(negedge clk);
    while (!w_rdy[ch] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("push_ready_ch%0d", ch), w_rdy[ch], 1);
    case (ch)
      0:       d0 = d;
      1:       d1 = d[6:0];
      default: d2 = d;
    endcase
    vld[ch] = 1'b1;
    qpush(ch, f);
    @(negedge clk);
    vld[ch] = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int budget);
    int t;
    t = 0;
    while ((w_busy[ch] || qsize(ch) != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("idle_busy_ch%0d", ch), w_busy[ch], 0);
    check($sformatf("idle_queue_ch%0d", ch), qsize(ch), 0);
  endtask

  task automatic wait_done0();
    int t;
    t = 0;
    while (!w_done[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", w_done[0], 1);
  endtask

  initial begin
    #600_000;
    n_fail++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int c0, acc, t, nd, gaps, hi;
    int dc[3];

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_out", w_tx[0], 1);
    check("rst_busy", w_busy[0], 0);
    check("rst_done", w_done[0], 0);
    check("rst_level", lvl0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", w_rdy[0], 1);

    // Single 8N1 frame of 0xA5 plus first-bit latency
    push(0, 8'hA5, 16'h034A);
    check("lat_level", lvl0, 1);
    check("lat_tx_idle", w_tx[0], 1);
    @(negedge clk);
    check("lat_tx_start", w_tx[0], 0);
    check("lat_busy", w_busy[0], 1);
    check("lat_level_popped", lvl0, 0);
    wait_idle(0, 400);

    // 7E2 with 0x35, then 8O1 with 0x00 and 0x01
    push(1, 8'h35, 16'h066A);
    push(2, 8'h00, 16'h0600);
    push(2, 8'h01, 16'h0402);
    wait_idle(1, 700);
    wait_idle(2, 900);

    // Hold valid for 20 words during a frame: only 16 fit
    push(0, 8'h3C, f8n1(8'h3C));
    @(negedge clk);
    c0 = cyc;
    check("t3_start", w_tx[0], 0);
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      d0     = 8'(8'h40 + k);
      vld[0] = 1'b1;
      if (w_rdy[0]) acc++;
      if (k < 16) q0.push_back(f8n1(8'(8'h40 + k)));
      @(negedge clk);
    end
    vld[0] = 1'b0;
    check("t3_accepted", acc, 16);
    check("t3_level_full", lvl0, 16);
    check("t3_ready_full", w_rdy[0], 0);
    t = 0;
    while (!w_rdy[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("t3_ready_reassert_cycle", cyc - c0, 250);
    check("t3_level_after_pop", lvl0, 15);
    wait_idle(0, 5000);

    // Back-to-back frames: no gap, done pulses 250 apart
    push(0, 8'h81, f8n1(8'h81));
    push(0, 8'h7E, f8n1(8'h7E));
    push(0, 8'hC3, f8n1(8'hC3));
    nd = 0; gaps = 0; t = 0;
    while (nd < 3 && t < 1000) begin
      @(negedge clk);
      t++;
      if (!w_busy[0]) gaps++;
      if (w_done[0]) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    check("t4_done_count", nd, 3);
    check("t4_busy_gaps", gaps, 0);
    check("t4_spacing_01", dc[1] - dc[0], 250);
    check("t4_spacing_12", dc[2] - dc[1], 250);
    wait_idle(0, 400);

    // Reset at cycle 100 of a frame with 4 words queued
    push(0, 8'h00, f8n1(8'h00));
    @(negedge clk);
    c0 = cyc;
    push(0, 8'h11, f8n1(8'h11));
    push(0, 8'h22, f8n1(8'h22));
    push(0, 8'h33, f8n1(8'h33));
    push(0, 8'h44, f8n1(8'h44));
    while (cyc - c0 < 99) @(negedge clk);
    check("t5_line_low_before_rst", w_tx[0], 0);
    check("t5_level_before_rst", lvl0, 4);
    #2;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("t5_tx_out_in_rst", w_tx[0], 1);
    check("t5_level_in_rst", lvl0, 0);
    check("t5_busy_in_rst", w_busy[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (w_busy[0] || !w_tx[0]) hi++;
    end
    check("t5_no_residual", hi, 0);
    check("t5_ready", w_rdy[0], 1);
    check("t5_level", lvl0, 0);
    push(0, 8'h5A, f8n1(8'h5A));
    wait_idle(0, 400);

    // Push+pop at level 5, then push rejected while full during a pop
    push(0, 8'h01, f8n1(8'h01));
    for (int k = 2; k <= 6; k++) push(0, 8'(k), f8n1(8'(k)));
    check("t6_level5", lvl0, 5);
    wait_done0();
    d0     = 8'hB7;
    vld[0] = 1'b1;
    q0.push_back(f8n1(8'hB7));
    @(negedge clk);
    vld[0] = 1'b0;
    check("t6_level_pushpop", lvl0, 5);
    for (int k = 0; k < 11; k++) push(0, 8'(8'hC0 + k), f8n1(8'(8'hC0 + k)));
    check("t6_level_full", lvl0, 16);
    check("t6_ready_full", w_rdy[0], 0);
    wait_done0();
    d0     = 8'hEE;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    check("t6_level_full_pop", lvl0, 15);
    wait_idle(0, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
